// File: rtl/rom_responder_if.sv
// rom_responder_if: nibble-bus signals shared by the CPU and a program-ROM responder
interface rom_responder_if;
  logic       halt;
  logic       sync;
  logic       rom_cmd;
  logic [3:0] data_i;
  logic [3:0] data_o;
  logic       data_en;
  modport master (output halt, sync, rom_cmd, data_i, input data_o, data_en);
  modport slave  (input halt, sync, rom_cmd, data_i, output data_o, data_en);
endinterface

// File: rtl/rom_responder.sv
// rom_responder: 4001-style program-ROM bus responder; optional I/O port when ROM_RESPONDER_IO_EN is defined
module rom_responder #(
  parameter logic [3:0] CHIP_ID = 4'h0,
  parameter int         ADDR_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  rom_responder_if.slave    bus,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic [3:0]        io_in,
  output logic [3:0]        io_out
);
  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} phase_t;
  phase_t     phase_q, phase_d;
  logic       locked_q, locked_d;
  logic [7:0] addr_q, addr_d;
  logic       selected_q, selected_d;
  logic       io_rd;
  // next phase, lock and address/chip-select capture
  always_comb begin
    phase_d    = bus.sync ? A1 : phase_t'(phase_q + 3'd1);
    locked_d   = locked_q | bus.sync;
    addr_d     = {(locked_q && phase_q == A2) ? bus.data_i : addr_q[7:4],
                  (locked_q && phase_q == A1) ? bus.data_i : addr_q[3:0]};
    selected_d = bus.sync ? 1'b0 :
                 (locked_q && phase_q == A3) ? (bus.data_i == CHIP_ID) : selected_q;
  end
  // fetch state; halt freezes everything
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      phase_q    <= X3;
      locked_q   <= 1'b0;
      addr_q     <= 8'h00;
      selected_q <= 1'b0;
    end else if (!bus.halt) begin
      phase_q    <= phase_d;
      locked_q   <= locked_d;
      addr_q     <= addr_d;
      selected_q <= selected_d;
    end
  assign mem_addr = addr_q[ADDR_W-1:0];
`ifdef ROM_RESPONDER_IO_EN
  logic       io_sel_q, io_sel_d;
  logic       io_pending_q, io_pending_d;
  logic [3:0] io_opa_q, io_opa_d;
  logic [3:0] io_out_q, io_out_d;
  logic       m2_cmd, x2_act;
  assign m2_cmd = locked_q && phase_q == M2 && bus.rom_cmd;
  assign x2_act = locked_q && phase_q == X2 && io_pending_q && io_sel_q;
  assign io_rd  = x2_act && io_opa_q == 4'hA;
  // SRC selection, snooped I/O opcode and WRR port write
  always_comb begin
    io_sel_d     = (locked_q && phase_q == X2 && bus.rom_cmd && !io_pending_q) ?
                   (bus.data_i == CHIP_ID) : io_sel_q;
    io_opa_d     = m2_cmd ? bus.data_i : io_opa_q;
    io_pending_d = (phase_q == X3 || bus.sync) ? 1'b0 : m2_cmd ? 1'b1 : io_pending_q;
    io_out_d     = (x2_act && io_opa_q == 4'h0) ? bus.data_i : io_out_q;
  end
  // I/O state; halt freezes everything
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      io_sel_q     <= 1'b0;
      io_pending_q <= 1'b0;
      io_opa_q     <= 4'h0;
      io_out_q     <= 4'h0;
    end else if (!bus.halt) begin
      io_sel_q     <= io_sel_d;
      io_pending_q <= io_pending_d;
      io_opa_q     <= io_opa_d;
      io_out_q     <= io_out_d;
    end
  assign io_out = io_out_q;
`else
  logic unused_io;
  assign unused_io = ^{bus.rom_cmd, io_in};
  assign io_rd     = 1'b0;
  assign io_out    = 4'h0;
`endif
  // bus drive decoded from registered phase: OPR in M1, OPA in M2, port read in X2
  always_comb begin
    bus.data_en = (locked_q && selected_q && (phase_q == M1 || phase_q == M2)) || io_rd;
    bus.data_o  = !bus.data_en ? 4'h0 :
                  phase_q == M1 ? mem_rdata[7:4] :
                  phase_q == M2 ? mem_rdata[3:0] : io_in;
  end
endmodule

// File: tb/tb_rom_responder.sv
// tb_rom_responder: directed nibble-bus cycles against a cycle-count model of the ROM responder
module tb_rom_responder;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic [3:0] io_in = 4'h0;
  logic [3:0] io_out;
  logic [7:0] rom [256];
  int n_chk = 0;
  int n_fail = 0;
  rom_responder_if bus();
  rom_responder #(.CHIP_ID(4'h0), .ADDR_W(8)) dut (
    .clock(clock), .reset(reset), .bus(bus), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .io_in(io_in), .io_out(io_out)
  );
  assign mem_rdata = rom[mem_addr];
  always #5 clock = ~clock;
  function automatic int ph(input int c);
    return c < 0 ? -1 : c % 8;
  endfunction
  // model: cycles elapsed since the last sync edge (-1 before any sync) plus captured nibbles
  int         cnt;
  logic [3:0] m_lo, m_hi, m_opa, m_io;
  logic       m_sel, m_iosel, m_pend;
  always @(posedge clock or posedge reset)
    if (reset) begin
      cnt <= -1; m_lo <= 4'h0; m_hi <= 4'h0; m_sel <= 1'b0;
      m_opa <= 4'h0; m_io <= 4'h0; m_iosel <= 1'b0; m_pend <= 1'b0;
    end else if (!bus.halt) begin
      cnt <= bus.sync ? 0 : (cnt < 0 ? -1 : cnt + 1);
      if (ph(cnt) == 0) m_lo <= bus.data_i;
      if (ph(cnt) == 1) m_hi <= bus.data_i;
      m_sel <= bus.sync ? 1'b0 : (ph(cnt) == 2) ? (bus.data_i == 4'h0) : m_sel;
`ifdef ROM_RESPONDER_IO_EN
      if (ph(cnt) == 6 && bus.rom_cmd && !m_pend) m_iosel <= (bus.data_i == 4'h0);
      if (ph(cnt) == 4 && bus.rom_cmd) m_opa <= bus.data_i;
      m_pend <= (ph(cnt) == 7 || bus.sync) ? 1'b0 : (ph(cnt) == 4 && bus.rom_cmd) ? 1'b1 : m_pend;
      if (ph(cnt) == 6 && m_pend && m_iosel && m_opa == 4'h0) m_io <= bus.data_i;
`endif
    end
  logic [7:0] e_byte;
  logic       e_hi, e_lo, e_rd, e_en;
  logic [3:0] e_o;
  assign e_byte = rom[{m_hi, m_lo}];
  assign e_hi   = m_sel && ph(cnt) == 3;
  assign e_lo   = m_sel && ph(cnt) == 4;
  assign e_rd   = m_pend && m_iosel && m_opa == 4'hA && ph(cnt) == 6;
  assign e_en   = e_hi || e_lo || e_rd;
  assign e_o    = e_hi ? e_byte[7:4] : e_lo ? e_byte[3:0] : e_rd ? io_in : 4'h0;
  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clock) begin
    chk("model_data_en", bus.data_en, e_en);
    chk("model_data_o", bus.data_o, e_o);
    chk("model_mem_addr", mem_addr, {m_hi, m_lo});
    chk("model_io_out", io_out, m_io);
  end
  task automatic tick(input logic s, input logic [3:0] d, input logic rc);
    bus.sync = s; bus.data_i = d; bus.rom_cmd = rc;
    @(posedge clock); #1;
  endtask
  task automatic addr_phase(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
    tick(1'b1, 4'h0, 1'b0);
    tick(1'b0, a1, 1'b0);
    tick(1'b0, a2, 1'b0);
    tick(1'b0, a3, 1'b0);
  endtask
  task automatic rest_phase(input logic [3:0] opa, input logic rc_m2, input logic [3:0] x2, input logic rc_x2);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, opa, rc_m2);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, x2, rc_x2);
  endtask
  initial begin
    bus.halt = 1'b0; bus.sync = 1'b0; bus.rom_cmd = 1'b0; bus.data_i = 4'h0;
    for (int i = 0; i < 256; i++) rom[i] = 8'(i * 7 + 3);
    rom[8'h2A] = 8'hD5;
    rom[8'h3C] = 8'h7E;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_data_en", bus.data_en, 8'h0);
    chk("rst_data_o", bus.data_o, 8'h0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_io_out", io_out, 8'h0);
    reset = 1'b0;
    repeat (10) tick(1'b0, 4'h5, 1'b0);
    chk("unlocked_en", bus.data_en, 8'h0);
    tick(1'b1, 4'h0, 1'b0);
    tick(1'b0, 4'hA, 1'b0);
    tick(1'b0, 4'h2, 1'b0);
    chk("addr_after_a2", mem_addr, 8'h2A);
    tick(1'b0, 4'h0, 1'b0);
    chk("m1_en", bus.data_en, 8'h1);
    chk("m1_opr", bus.data_o, 8'hD);
    tick(1'b0, 4'h0, 1'b0);
    chk("m2_en", bus.data_en, 8'h1);
    chk("m2_opa", bus.data_o, 8'h5);
    tick(1'b0, 4'h0, 1'b0);
    chk("x1_en", bus.data_en, 8'h0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    addr_phase(4'hA, 4'h2, 4'h3);
    chk("other_chip_m1_en", bus.data_en, 8'h0);
    tick(1'b0, 4'h0, 1'b0);
    chk("other_chip_m2_en", bus.data_en, 8'h0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    addr_phase(4'hA, 4'h2, 4'h0);
    chk("reselect_m1_en", bus.data_en, 8'h1);
    chk("reselect_m1_opr", bus.data_o, 8'hD);
    rest_phase(4'h0, 1'b0, 4'h0, 1'b0);
    tick(1'b1, 4'h0, 1'b0);
    tick(1'b0, 4'hC, 1'b0);
    bus.halt = 1'b1;
    repeat (3) tick(1'b0, 4'hF, 1'b1);
    chk("halt_addr", mem_addr, 8'h2C);
    bus.halt = 1'b0;
    tick(1'b0, 4'h3, 1'b0);
    chk("post_halt_addr", mem_addr, 8'h3C);
    tick(1'b0, 4'h0, 1'b0);
    chk("post_halt_opr", bus.data_o, 8'h7);
    tick(1'b0, 4'h0, 1'b0);
    chk("post_halt_opa", bus.data_o, 8'hE);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b1, 4'h0, 1'b0);
    tick(1'b0, 4'hA, 1'b0);
    tick(1'b0, 4'h2, 1'b0);
    tick(1'b1, 4'h0, 1'b0);
    tick(1'b0, 4'h1, 1'b0);
    tick(1'b0, 4'h4, 1'b0);
    chk("resync_addr", mem_addr, 8'h41);
    tick(1'b0, 4'h3, 1'b0);
    chk("resync_m1_en", bus.data_en, 8'h0);
    rest_phase(4'h0, 1'b0, 4'h0, 1'b0);
`ifdef ROM_RESPONDER_IO_EN
    addr_phase(4'hA, 4'h2, 4'h0);
    rest_phase(4'h0, 1'b0, 4'h0, 1'b1);
    chk("src_io_out", io_out, 8'h0);
    addr_phase(4'hA, 4'h2, 4'h0);
    rest_phase(4'h0, 1'b1, 4'h9, 1'b1);
    chk("wrr_io_out", io_out, 8'h9);
    io_in = 4'h6;
    addr_phase(4'hA, 4'h2, 4'h0);
    tick(1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'hA, 1'b1);
    tick(1'b0, 4'h0, 1'b0);
    chk("rdr_en", bus.data_en, 8'h1);
    chk("rdr_data", bus.data_o, 8'h6);
    tick(1'b0, 4'h0, 1'b0);
    chk("rdr_io_out", io_out, 8'h9);
    addr_phase(4'hA, 4'h2, 4'h0);
    rest_phase(4'h0, 1'b0, 4'h0, 1'b0);
`endif
    addr_phase(4'hA, 4'h2, 4'h0);
    chk("pre_reset_en", bus.data_en, 8'h1);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_en", bus.data_en, 8'h0);
    chk("async_rst_data_o", bus.data_o, 8'h0);
    chk("async_rst_io_out", io_out, 8'h0);
    chk("async_rst_addr", mem_addr, 8'h00);
    @(posedge clock); #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) tick(1'b0, 4'h0, 1'b0);
    chk("post_reset_unlocked_en", bus.data_en, 8'h0);
    addr_phase(4'hA, 4'h2, 4'h0);
    chk("relock_m1_en", bus.data_en, 8'h1);
    chk("relock_m1_opr", bus.data_o, 8'hD);
    rest_phase(4'h0, 1'b0, 4'h0, 1'b0);
    tick(1'b0, 4'h0, 1'b0);
    @(negedge clock); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
